// File: rtl/key_pkg.sv
// key_pkg: shared FSM state encoding and default gap length for key_event_scheduler
package key_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_GAP     = 2'd2
  } state_e;
  localparam logic [23:0] GAP_100MS = 24'd9_999_999;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit scanning from ptr upward with wrap
//   req     - request vector, bit i = key i
//   ptr     - scan start index (always < N_KEYS)
//   gnt_any - at least one request set
//   gnt_idx - index of the granted request
module rr_arbiter #(
  parameter int N_KEYS    = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [N_KEYS-1:0]    req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 gnt_any,
  output logic [IDX_WIDTH-1:0] gnt_idx
);
  function automatic logic [IDX_WIDTH-1:0] rot(input logic [IDX_WIDTH-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return IDX_WIDTH'(s >= N_KEYS ? s - N_KEYS : s);
  endfunction
  // scan farthest-first so the nearest set bit to ptr is the last (winning) write
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      if (req[rot(ptr, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rot(ptr, k);
      end
    end
  end
endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: latches key pulses, grants them round-robin over valid/ready, then holds a minimum gap
//   clk, rst_n - clock, synchronous active-low reset
//   key_flag   - one-cycle press pulses, bit i = key i
//   evt_valid  - event presented on evt_key
//   evt_key    - granted key index, stable while evt_valid
//   evt_ready  - consumer accepts when evt_valid is high
//   busy       - presenting an event or inside the post-accept gap
//   overrun    - sticky per-key lost-press flags
//   ovr_clr    - clears all overrun flags
module key_event_scheduler
  import key_pkg::*;
#(
  parameter int                   N_KEYS    = 4,
  parameter int                   IDX_WIDTH = 2,
  parameter int                   GAP_WIDTH = 24,
  parameter logic [GAP_WIDTH-1:0] GAP_MAX   = GAP_100MS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_KEYS-1:0]    key_flag,
  output logic                 evt_valid,
  output logic [IDX_WIDTH-1:0] evt_key,
  input  logic                 evt_ready,
  output logic                 busy,
  output logic [N_KEYS-1:0]    overrun,
  input  logic                 ovr_clr
);
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(N_KEYS - 1);
  state_e                 state_q, state_d;
  logic [N_KEYS-1:0]      pending_q, pending_d, overrun_q, overrun_d, clr;
  logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d, evt_key_q, evt_key_d, gnt_idx;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   evt_valid_q, evt_valid_d, gnt_any, grant;

  rr_arbiter #(.N_KEYS(N_KEYS), .IDX_WIDTH(IDX_WIDTH)) u_arb (
    .req     (pending_q),
    .ptr     (rr_ptr_q),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  assign grant = (state_q == S_IDLE) && gnt_any;
  assign clr   = grant ? ({{(N_KEYS-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  // a press coinciding with its own grant re-arms pending instead of counting as overrun
  assign pending_d = (pending_q & ~clr) | key_flag;
  assign overrun_d = (ovr_clr ? '0 : overrun_q) | (key_flag & pending_q & ~clr);

  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    rr_ptr_d    = rr_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      S_IDLE: if (gnt_any) begin
        evt_key_d   = gnt_idx;
        evt_valid_d = 1'b1;
        state_d     = S_PRESENT;
      end
      S_PRESENT: if (evt_ready) begin
        evt_valid_d = 1'b0;
        rr_ptr_d    = evt_key_q == LAST ? '0 : evt_key_q + 1'b1;
        gap_cnt_d   = '0;
        state_d     = S_GAP;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q == GAP_MAX ? '0 : gap_cnt_q + GAP_WIDTH'(1);
        state_d   = gap_cnt_q == GAP_MAX ? S_IDLE : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      overrun_q   <= '0;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign busy      = state_q != S_IDLE;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: randomized and directed stimulus against a transaction-level scheduler model with a scoreboard
module tb_key_event_scheduler;
  localparam int N = 4, IW = 2, GW = 24;
  localparam logic [GW-1:0] GM = 24'd3;

  logic          clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b0, ovr_clr = 1'b0;
  logic [N-1:0]  key_flag = '0;
  logic          evt_valid, busy;
  logic [IW-1:0] evt_key;
  logic [N-1:0]  overrun;

  always #5 clk = ~clk;

  key_event_scheduler #(.N_KEYS(N), .IDX_WIDTH(IW), .GAP_WIDTH(GW), .GAP_MAX(GM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_flag  (key_flag),
    .evt_valid (evt_valid),
    .evt_key   (evt_key),
    .evt_ready (evt_ready),
    .busy      (busy),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  typedef struct {int key; int cyc;} exp_t;
  exp_t exp_q[$];
  int   checks = 0, errors = 0, cyc = 0;

  // model: set of waiting keys, a rotating start position, and a phase with a countdown for the gap
  bit m_pend[N];
  bit m_ovr[N];
  int m_ptr = 0, m_mode = 0, m_left = 0, m_cur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    int   g;
    exp_t e;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ovr[i] = 0; end
      m_ptr = 0; m_mode = 0; m_left = 0; m_cur = 0;
    end else begin
      g = -1;
      if (m_mode == 0) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) begin
          m_mode = 1; m_cur = g;
          e.key = g; e.cyc = cyc;
          exp_q.push_back(e);
        end
      end else if (m_mode == 1) begin
        if (evt_ready) begin m_ptr = (m_cur + 1) % N; m_mode = 2; m_left = int'(GM) + 1; end
      end else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
      if (ovr_clr) for (int i = 0; i < N; i++) m_ovr[i] = 0;
      for (int i = 0; i < N; i++) begin
        if (key_flag[i]) begin
          if (m_pend[i] && g != i) m_ovr[i] = 1;
          m_pend[i] = 1;
        end else if (g == i) m_pend[i] = 0;
      end
    end
  end

  logic          prev_v = 1'b0;
  logic [IW-1:0] prev_k = '0;
  always @(negedge clk) begin
    logic [N-1:0] mv;
    exp_t e;
    for (int i = 0; i < N; i++) mv[i] = m_ovr[i];
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("evt_valid", 32'(evt_valid), 32'(m_mode == 1));
    check("overrun", 32'(overrun), 32'(mv));
    if (evt_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event at cycle %0d: got key %0d, expected no event", cyc, evt_key);
      end else begin
        e = exp_q.pop_front();
        check("evt_key", 32'(evt_key), 32'(e.key));
        check("evt_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (evt_valid && prev_v) check("key_stable", 32'(evt_key), 32'(prev_k));
    prev_v = evt_valid;
    prev_k = evt_key;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [N-1:0] k);
    @(negedge clk); key_flag = k;
    @(negedge clk); key_flag = '0;
  endtask

  initial begin
    logic [31:0] r;
    tick(3);
    check("rst_evt_key", 32'(evt_key), 32'd0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    press(4'b0100); tick(10);
    press(4'b1111); tick(30);
    press(4'b0100); tick(1); press(4'b1001); tick(30);
    evt_ready = 1'b0;
    press(4'b0001); tick(10);
    evt_ready = 1'b1; tick(10);
    evt_ready = 1'b0;
    press(4'b0001); tick(2);
    press(4'b0010); press(4'b0010); press(4'b0010); tick(3);
    evt_ready = 1'b1; tick(20);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    tick(3);
    evt_ready = 1'b0;
    press(4'b0001); tick(1); press(4'b0110); tick(1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; evt_ready = 1'b1;
    tick(20);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom;
      key_flag  = $urandom_range(0, 6) == 0 ? r[N-1:0] : '0;
      evt_ready = $urandom_range(0, 2) != 0;
      ovr_clr   = $urandom_range(0, 30) == 0;
      rst_n     = $urandom_range(0, 500) != 0;
    end
    @(negedge clk);
    key_flag = '0; ovr_clr = 1'b0; rst_n = 1'b1; evt_ready = 1'b1;
    tick(80);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
